sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
// Registered arbiter directly upstream of the sdram controller; replaces the combinational port mux.
// Merges three requesters into one sdram port: downloader writes, eraser writes and Z80 read/write.
// Grants one access per clkref slot and holds address, data and controls stable for the whole slot.
// Buffers downloader bytes in a small FIFO so a strobe arriving mid-slot is never lost.
// PARAMETERS
// ADDR_W      25  sdram byte address width
// DATA_W      8   data width
// DL_DEPTH    4   downloader FIFO depth; power of two, >=2
// PORTS
// sys_clock    in   1       system clock; the sdram controller clock
// res_n        in   1       synchronous active-low reset
// clkref       in   1       cpu_clock; its rising edge marks a slot boundary (8 sys_clock per slot)
// dl_wr        in   1       downloader write strobe, 1-cycle pulse
// dl_addr      in   ADDR_W  downloader address
// dl_data      in   DATA_W  downloader data
// dl_full      out  1       FIFO holds DL_DEPTH entries
// dl_overflow  out  1       sticky: a dl_wr arrived while full; cleared only by reset
// er_wr        in   1       eraser write request, level
// er_addr      in   ADDR_W  eraser address
// er_data      in   DATA_W  eraser data
// er_ack       out  1       1-cycle pulse: eraser write committed
// cpu_addr     in   16      Z80 address, zero-extended to ADDR_W
// cpu_din      in   DATA_W  Z80 write data
// cpu_rd       in   1       Z80 read request, level
// cpu_wr       in   1       Z80 write request, level; wins over cpu_rd if both are high
// cpu_dout     out  DATA_W  read data; holds its value until the next CPU read completes
// cpu_ack      out  1       1-cycle pulse: CPU access done
// sd_addr      out  ADDR_W  to sdram addr
// sd_din       out  DATA_W  to sdram din
// sd_we        out  1       to sdram we
// sd_oe        out  1       to sdram oe
// sd_dout      in   DATA_W  from sdram dout
// owner        out  2       current grant: 0 IDLE, 1 DL, 2 ER, 3 CPU
// BEHAVIOUR
// - Slot boundary: clkref_q is registered; slot_start = clkref & ~clkref_q (one cycle wide).
// - Reset (res_n=0 at a sys_clock edge): all outputs 0, owner=IDLE, FIFO empty, overflow cleared, clkref_q=0.
//   Reset mid-slot aborts the access; sd_we and sd_oe are 0 on the next cycle. No ack is issued.
// - Priority, evaluated only on slot_start cycles: FIFO non-empty -> DL; else er_wr -> ER;
//   else cpu_wr|cpu_rd -> CPU; else IDLE.
// - The grant state machine has states IDLE, DL, ER and CPU, and changes state only on slot_start.
// - On the granting edge:
//   - sd_addr, sd_din, sd_we and sd_oe are registered and held constant until the next slot_start.
//   - sd_we=1 for DL, ER and CPU-write; sd_oe = ~sd_we when granted, 0 in IDLE.
//   - DL pops the FIFO head on the same edge.
// - Completion at the next slot_start edge, simultaneous with the next grant:
//   - CPU read: cpu_dout <= sd_dout and cpu_ack pulses.
//   - CPU write: cpu_ack pulses.
//   - ER: er_ack pulses.
// - Latency: request sampled at slot S -> ack one slot later (8 sys_clock for a steady clkref).
// - Requester deasserting mid-slot: the access still completes and the ack is still pulsed. Requesters are never aborted.
// - CPU and ER are starved while the FIFO is non-empty. This is intended: the system holds WAIT and RESET during download and erase.
// - FIFO:
//   - push on dl_wr & ~full; a simultaneous push and pop is legal (count unchanged).
//   - dl_wr while full: the byte is dropped, dl_overflow <= 1, and FIFO contents are unchanged.
//   - Pointers wrap modulo DL_DEPTH; count is $clog2(DL_DEPTH)+1 bits wide.
//   - dl_full is registered and valid the cycle after the push that fills the FIFO.
// - clkref stuck (no rising edge): the current grant stays held indefinitely and no ack is issued.
// STRUCTURE
// - Package lm80c_mem_pkg:
//   - owner_t enum {OWN_IDLE, OWN_DL, OWN_ER, OWN_CPU}
//   - SDRAM_ADDR_W=25, SDRAM_DATA_W=8
// - Sub-module sdram_dl_fifo (sync FIFO; ports: push, pop, din, dout, empty, full, overflow).
// - Grant FSM, slot-edge detector and output registers stay in this module.
// TESTING
// - Reset held 3 cycles with dl_wr=1 and cpu_rd=1 -> all outputs 0, owner=0, dl_overflow=0.
// - cpu_rd=1, cpu_addr=16'h8241, sdram model returns 8'h5A -> sd_addr=25'h0008241 and sd_oe=1 for the whole slot; next slot_start: cpu_dout=8'h5A, cpu_ack one cycle.
// - 4 dl_wr pulses in consecutive cycles (addr 0..3, data A0..A3) -> dl_full=1; they drain in 4 slots, in order, with sd_we=1; no overflow.
// - 5th dl_wr while full -> dl_overflow=1 sticky; only 4 writes reach the sdram.
// - er_wr and cpu_wr both high -> ER granted first, er_ack pulses; CPU granted in the next slot, cpu_ack one slot later.
// - dl_wr arrives in the same cycle as slot_start with the FIFO non-empty -> push and pop together, count unchanged, order preserved.
// - Reset asserted in cycle 3 of a CPU-write slot -> sd_we=0 next cycle, no cpu_ack; normal operation after release.

Source files
------------

// File: rtl/lm80c_mem_pkg.sv
// lm80c_mem_pkg: shared sdram port widths and grant owner encoding
package lm80c_mem_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 8;

    typedef enum logic [1:0] {OWN_IDLE, OWN_DL, OWN_ER, OWN_CPU} owner_t;

endpackage

// File: rtl/sdram_dl_fifo.sv
// sdram_dl_fifo: downloader byte FIFO with registered full and sticky overflow
module sdram_dl_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic         sys_clock,
    input  logic         res_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   count, count_n;
    logic          do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = count == '0;
    assign dout    = mem[rp];
    assign count_n = count + (PW+1)'(do_push) - (PW+1)'(do_pop);

    always_ff @(posedge sys_clock)
        if (do_push)
            mem[wp] <= din;

    always_ff @(posedge sys_clock) begin
        if (!res_n) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wp       <= do_push ? wp + 1'b1 : wp;
            rp       <= do_pop ? rp + 1'b1 : rp;
            count    <= count_n;
            full     <= count_n == (PW+1)'(DEPTH);
            overflow <= overflow | (push & full);
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: slot-synchronous arbiter merging downloader, eraser and Z80 onto one sdram port
module sdram_port_arbiter
    import lm80c_mem_pkg::*;
#(
    parameter int ADDR_W   = SDRAM_ADDR_W,
    parameter int DATA_W   = SDRAM_DATA_W,
    parameter int DL_DEPTH = 4
) (
    input  logic              sys_clock,
    input  logic              res_n,
    input  logic              clkref,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [DATA_W-1:0] dl_data,
    output logic              dl_full,
    output logic              dl_overflow,
    input  logic              er_wr,
    input  logic [ADDR_W-1:0] er_addr,
    input  logic [DATA_W-1:0] er_data,
    output logic              er_ack,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [DATA_W-1:0] sd_din,
    output logic              sd_we,
    output logic              sd_oe,
    input  logic [DATA_W-1:0] sd_dout,
    output logic [1:0]        owner
);

    owner_t              state, state_n;
    logic                clkref_q, slot_start, fifo_empty, cpu_is_wr, cpu_is_wr_n;
    logic                we_n, oe_n, cpu_ack_n, er_ack_n;
    logic [ADDR_W-1:0]   fifo_addr, addr_n;
    logic [DATA_W-1:0]   fifo_data, din_n, dout_n;

    assign slot_start = clkref & ~clkref_q;
    assign owner      = state;

    sdram_dl_fifo #(.DEPTH(DL_DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
        .sys_clock (sys_clock),
        .res_n     (res_n),
        .push      (dl_wr),
        .pop       (slot_start & ~fifo_empty),
        .din       ({dl_addr, dl_data}),
        .dout      ({fifo_addr, fifo_data}),
        .empty     (fifo_empty),
        .full      (dl_full),
        .overflow  (dl_overflow)
    );

    // Grant and completion both happen only on slot_start; otherwise everything holds.
    always_comb begin
        state_n     = state;
        addr_n      = sd_addr;
        din_n       = sd_din;
        we_n        = sd_we;
        oe_n        = sd_oe;
        cpu_is_wr_n = cpu_is_wr;
        if (slot_start) begin
            state_n     = !fifo_empty ? OWN_DL : er_wr ? OWN_ER : (cpu_wr | cpu_rd) ? OWN_CPU : OWN_IDLE;
            addr_n      = !fifo_empty ? fifo_addr : er_wr ? er_addr : (cpu_wr | cpu_rd) ? ADDR_W'(cpu_addr) : '0;
            din_n       = !fifo_empty ? fifo_data : er_wr ? er_data : cpu_wr ? cpu_din : '0;
            we_n        = !fifo_empty | er_wr | cpu_wr;
            oe_n        = fifo_empty & ~er_wr & ~cpu_wr & cpu_rd;
            cpu_is_wr_n = cpu_wr;
        end
        cpu_ack_n = slot_start && state == OWN_CPU;
        er_ack_n  = slot_start && state == OWN_ER;
        dout_n    = (cpu_ack_n && !cpu_is_wr) ? sd_dout : cpu_dout;
    end

    always_ff @(posedge sys_clock) begin
        if (!res_n) begin
            state     <= OWN_IDLE;
            clkref_q  <= 1'b0;
            sd_addr   <= '0;
            sd_din    <= '0;
            sd_we     <= 1'b0;
            sd_oe     <= 1'b0;
            cpu_is_wr <= 1'b0;
            cpu_ack   <= 1'b0;
            er_ack    <= 1'b0;
            cpu_dout  <= '0;
        end else begin
            state     <= state_n;
            clkref_q  <= clkref;
            sd_addr   <= addr_n;
            sd_din    <= din_n;
            sd_we     <= we_n;
            sd_oe     <= oe_n;
            cpu_is_wr <= cpu_is_wr_n;
            cpu_ack   <= cpu_ack_n;
            er_ack    <= er_ack_n;
            cpu_dout  <= dout_n;
        end
    end

endmodule
